// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hs_pkg
//  Description : Shared definitions for the 8-bit valid/ready handshake slave:
//                default widths and the FIFO occupancy state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

    localparam int HS_DATA_W = 8;   // default payload width
    localparam int HS_CNT_W  = 16;  // width of the optional statistics counters

    // Occupancy of the receive FIFO.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } hs_state_t;

endpackage : hs_pkg
`default_nettype wire

// File: rtl/hs_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hs_sync_fifo
//  Description : Small synchronous FIFO: storage, read/write pointers, entry
//                count and occupancy state. Push/pop qualification is done by
//                the caller; this block trusts i_push/i_pop.
//  Ports       : clk         - clock, rising edge
//                rst         - synchronous reset, active low
//                i_push      - write i_wdata at the write pointer
//                i_wdata     - write payload
//                i_pop       - retire the head entry
//                o_rdata     - head entry (mem[rd_ptr])
//                o_count_nxt - entry count after the current edge
//                o_state     - registered occupancy state
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = 4           // power of two, at least 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [$clog2(DEPTH):0]     o_count_nxt,
    output hs_state_t                  o_state
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_count_nxt;
    hs_state_t         r_state;

    always_comb begin
        w_count_nxt = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_nxt = r_count + PTR_W'(1);
            2'b01:   w_count_nxt = r_count - PTR_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Storage is cleared so the head output reads zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= EMPTY;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
                r_wr_ptr                    <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;

            case (r_state)
                EMPTY: begin
                    if (i_push) begin
                        r_state <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (i_push && !i_pop && (r_count == PTR_W'(DEPTH - 1))) begin
                        r_state <= FULL;
                    end else if (i_pop && !i_push && (r_count == PTR_W'(1))) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (i_pop && !i_push) begin
                        r_state <= PARTIAL;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign o_rdata     = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign o_count_nxt = w_count_nxt;
    assign o_state     = r_state;

endmodule : hs_sync_fifo
`default_nettype wire

// File: rtl/handshake_slave.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_slave
//  Description : Receiving end of the 8-bit valid/ready handshake. Accepted
//                beats are buffered in hs_sync_fifo and offered to a
//                downstream consumer over a second valid/ready port.
//                Optional statistics counters are built when the macro
//                HS_SLAVE_COUNT_EN is defined.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous reset, active low
//                valid      - master beat present
//                data_in    - master payload
//                ready      - slave can accept a beat (registered)
//                out_data   - head-of-FIFO payload
//                out_valid  - out_data is valid
//                out_ready  - consumer accepts the head beat
//                rx_count   - beats accepted (HS_SLAVE_COUNT_EN only)
//                drop_count - cycles with valid=1, ready=0 (HS_SLAVE_COUNT_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_slave
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int DEPTH  = 4           // power of two, at least 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [DATA_W-1:0]   data_in,
    output logic                ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
`ifdef HS_SLAVE_COUNT_EN
    ,
    output logic [HS_CNT_W-1:0] rx_count,
    output logic [HS_CNT_W-1:0] drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic             r_ready;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_count_nxt;
    hs_state_t        w_state;

    // Both handshakes qualify only on registered signals, so out_ready never
    // reaches ready combinationally and nothing bypasses the FIFO.
    assign w_push = valid & r_ready;
    assign w_pop  = out_valid & out_ready;

    hs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_wdata     (data_in),
        .i_pop       (w_pop),
        .o_rdata     (out_data),
        .o_count_nxt (w_count_nxt),
        .o_state     (w_state)
    );

    // ready follows the post-edge occupancy, so a pop from FULL re-opens the
    // input one cycle later. It is held low through the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_count_nxt < PTR_W'(DEPTH));
        end
    end

    assign ready     = r_ready;
    assign out_valid = (w_state != EMPTY);

`ifdef HS_SLAVE_COUNT_EN
    logic [HS_CNT_W-1:0] r_rx_count;
    logic [HS_CNT_W-1:0] r_drop_count;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push && (r_rx_count != '1)) begin
                r_rx_count <= r_rx_count + HS_CNT_W'(1);
            end
            if (valid && !r_ready && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + HS_CNT_W'(1);
            end
        end
    end

    assign rx_count   = r_rx_count;
    assign drop_count = r_drop_count;
`endif

endmodule : handshake_slave
`default_nettype wire

// File: tb/tb_handshake_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_slave
//  Description : Self-checking bench for handshake_slave. A queue-based
//                model of the buffered byte stream predicts ready, out_valid,
//                out_data and (with HS_SLAVE_COUNT_EN) the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_slave;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  data_in;
    logic        ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef HS_SLAVE_COUNT_EN
    logic [15:0] rx_count;
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    handshake_slave #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .data_in    (data_in),
        .ready      (ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef HS_SLAVE_COUNT_EN
        ,
        .rx_count   (rx_count),
        .drop_count (drop_count)
`endif
    );

    // Reference model: contents of the buffer as a queue of bytes.
    logic [7:0] m_q [$];
    bit         m_ready    = 1'b0;
    bit         m_rst_edge = 1'b0;
    int         m_rx       = 0;
    int         m_drop     = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: apply the model at the edge, compare on the falling edge.
    task automatic tick();
        bit do_push;
        bit do_pop;
        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_ready    = 1'b0;
            m_rx       = 0;
            m_drop     = 0;
            m_rst_edge = 1'b1;
        end else begin
            m_rst_edge = 1'b0;
            do_push = valid && m_ready;
            do_pop  = (m_q.size() != 0) && out_ready;
            if (valid && !m_ready && m_drop < 65535) m_drop++;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(data_in);
                if (m_rx < 65535) m_rx++;
            end
            m_ready = (m_q.size() < DEPTH);
        end
        @(negedge clk);
        chk("ready", {31'd0, ready}, {31'd0, m_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0)});
        if (m_q.size() != 0)
            chk("out_data", {24'd0, out_data}, {24'd0, m_q[0]});
        else if (m_rst_edge)
            chk("out_data_rst", {24'd0, out_data}, 32'd0);
`ifdef HS_SLAVE_COUNT_EN
        chk("rx_count", {16'd0, rx_count}, m_rx);
        chk("drop_count", {16'd0, drop_count}, m_drop);
`endif
    endtask

    // Hold one beat on the input until the model says it was accepted.
    task automatic push_beat(input logic [7:0] d);
        bit acc;
        acc     = 1'b0;
        valid   = 1'b1;
        data_in = d;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = m_ready;
            tick();
        end
        valid = 1'b0;
        chk("push_accept", {31'd0, acc}, 32'd1);
    endtask

    initial begin
        // Reset held 3 cycles with a beat offered: nothing may be stored.
        rst       = 1'b0;
        valid     = 1'b1;
        data_in   = 8'hAA;
        out_ready = 1'b0;
        repeat (3) tick();
        rst   = 1'b1;
        valid = 1'b0;
        tick();
        tick();

        // Single beat, then a one-cycle consumer pulse.
        push_beat(8'h3C);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        // Fill, stall a fifth beat, pop once from FULL, then drain.
        for (int i = 1; i <= 4; i++) push_beat(8'(i));
        valid   = 1'b1;
        data_in = 8'h05;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        push_beat(8'h05);
        out_ready = 1'b1;
        repeat (5) tick();

        // Back-to-back streaming through the pointer wrap.
        valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(i);
            tick();
        end
        valid = 1'b0;
        repeat (2) tick();

        // Reset with beats buffered, then a fresh beat must lead.
        out_ready = 1'b0;
        push_beat(8'h11);
        push_beat(8'h22);
        push_beat(8'h33);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        push_beat(8'h77);
        out_ready = 1'b1;
        repeat (2) tick();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) != 0);
            valid     = ($urandom_range(0, 2) != 0);
            data_in   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0) ^ (i[9] & ($urandom_range(0, 1) != 0));
            tick();
        end
        rst = 1'b1;
        valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_handshake_slave
`default_nettype wire
